// File: rtl/arb_pkg.sv
// Shared types and defaults for the instruction/data memory-bus arbiter.
// State encodings are fixed because debug tooling decodes the raw state bits.
package arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_INST = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_t;

  localparam int DEF_ADDR_W       = 32;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_STARVE_LIMIT = 4;
  localparam int DEF_TIMEOUT      = 255;

endpackage

// File: rtl/arb_req_latch.sv
// Holds the granted request's address, store data and write flag for the bus.
// Loads in the grant cycle; outputs stay stable until the next grant.
module arb_req_latch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              we,
  output logic [ADDR_W-1:0] addr_q,
  output logic [DATA_W-1:0] wdata_q,
  output logic              we_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else if (load) begin
      addr_q  <= addr;
      wdata_q <= wdata;
      we_q    <= we;
    end
  end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Arbitrates IF fetches and MEM loads/stores onto one req/ack memory bus.
// A grant costs >=2 cycles; ready pulses the cycle after ack; stalls hold requesters meanwhile.
module imem_dmem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_ren,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_data,
  output logic              inst_ready,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_ready,
  output logic              if_stall,
  output logic              mem_stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              timeout_err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [7:0]    WAIT_LAST  = 8'(TIMEOUT - 1);

  arb_state_t state_q, state_d;
  logic [SW-1:0] starve_cnt;
  logic [7:0]    wait_cnt;
  logic          data_req;
  logic          grant_data;
  logic          grant_inst;
  logic          finish;
  logic          timeout_hit;

  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;
  logic              lat_we;

  assign data_req    = mem_ren | mem_wen;
  // wait_cnt is 0 on the first WAIT cycle, so TIMEOUT-1 marks the TIMEOUT-th cycle.
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == WAIT_LAST);

  always_comb begin
    state_d    = state_q;
    grant_data = 1'b0;
    grant_inst = 1'b0;
    finish     = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (data_req && (!inst_ren || (starve_cnt < STARVE_MAX))) begin
          grant_data = 1'b1;
          state_d    = ARB_DATA;
        end else if (inst_ren) begin
          grant_inst = 1'b1;
          state_d    = ARB_INST;
        end
      end
      ARB_INST, ARB_DATA: begin
        if (bus_ack || timeout_hit) begin
          finish  = 1'b1;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ARB_IDLE;
    else        state_q <= state_d;
  end

  assign sel_addr  = grant_data ? mem_addr : inst_addr;
  assign sel_wdata = grant_data ? mem_dout : '0;
  assign sel_we    = grant_data & mem_wen;

  arb_req_latch #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_req_latch (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (grant_data | grant_inst),
    .addr    (sel_addr),
    .wdata   (sel_wdata),
    .we      (sel_we),
    .addr_q  (bus_addr),
    .wdata_q (bus_wdata),
    .we_q    (lat_we)
  );

  // Async reset of state_q drops bus_req immediately, even mid-transaction.
  assign bus_req = (state_q != ARB_IDLE);
  assign bus_we  = bus_req & lat_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                wait_cnt <= '0;
    else if (state_q == ARB_IDLE) wait_cnt <= '0;
    else                       wait_cnt <= wait_cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!inst_ren || grant_inst) begin
      starve_cnt <= '0;
    end else if (grant_data && (starve_cnt != STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_ready  <= 1'b0;
      mem_ready   <= 1'b0;
      inst_data   <= '0;
      mem_din     <= '0;
      timeout_err <= 1'b0;
    end else begin
      inst_ready <= finish && (state_q == ARB_INST);
      mem_ready  <= finish && (state_q == ARB_DATA);
      if (finish && (state_q == ARB_INST)) begin
        inst_data <= bus_ack ? bus_rdata : '0;
      end
      // A completed store leaves mem_din alone; an aborted access of either kind returns 0.
      if (finish && (state_q == ARB_DATA) && (!lat_we || !bus_ack)) begin
        mem_din <= bus_ack ? bus_rdata : '0;
      end
      if (finish && !bus_ack) begin
        timeout_err <= 1'b1;
      end
    end
  end

  assign if_stall  = inst_ren & ~inst_ready;
  assign mem_stall = data_req & ~mem_ready;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Bench for imem_dmem_arbiter: directed scenarios plus randomized request streams
// checked against a transaction-level arbitration model and a memory model.
module tb_imem_dmem_arbiter;

  localparam int LIMIT  = 4;
  localparam int TO     = 8;
  localparam int NO_ACK = 255;

  logic        clk, rst_n;
  logic        inst_ren, inst_ready, mem_ren, mem_wen, mem_ready;
  logic        if_stall, mem_stall, bus_req, bus_we, bus_ack, timeout_err;
  logic [31:0] inst_addr, inst_data, mem_addr, mem_dout, mem_din;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  typedef struct packed {
    logic        we;
    logic        both;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] mm  [logic [31:0]];

  int   age = 0;
  int   cur_lat = 1;
  int   bus_lat = 1;
  bit   rand_lat = 0;
  bit   started = 0;
  bit   stray_pend = 0;
  logic [31:0] req_addr, req_wdata;
  logic        req_we;

  txn_t iq[$], dq[$], exp_q[$];
  int   ip, dp, ek;
  logic [31:0] exp_inst_data = '0;
  logic [31:0] exp_mem_din   = '0;

  imem_dmem_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .STARVE_LIMIT (LIMIT),
    .TIMEOUT      (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .inst_ren    (inst_ren),
    .inst_addr   (inst_addr),
    .inst_data   (inst_data),
    .inst_ready  (inst_ready),
    .mem_ren     (mem_ren),
    .mem_wen     (mem_wen),
    .mem_addr    (mem_addr),
    .mem_dout    (mem_dout),
    .mem_din     (mem_din),
    .mem_ready   (mem_ready),
    .if_stall    (if_stall),
    .mem_stall   (mem_stall),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_rdata   (bus_rdata),
    .bus_ack     (bus_ack),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && bus_req)
      assert (bus_addr[1:0] == 2'b00) else $error("FAIL misaligned: bus_addr=%h", bus_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_word(a);
  endfunction

  // One clock: sample just after the edge, then play the bus slave for this cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    bus_ack   = 1'b0;
    bus_rdata = $urandom;
    started   = 0;
    if (!bus_req) begin
      age = 0;
    end else begin
      age++;
      if (age == 1) begin
        cur_lat   = rand_lat ? int'($urandom_range(1, 4)) : bus_lat;
        req_addr  = bus_addr;
        req_we    = bus_we;
        req_wdata = bus_wdata;
        started   = 1;
      end
      if (cur_lat != NO_ACK && age == cur_lat + 1) begin
        bus_ack = 1'b1;
        if (bus_we) mem[bus_addr] = bus_wdata;
        else        bus_rdata = mem_rd(bus_addr);
      end
    end
    if (stray_pend) begin
      bus_ack    = 1'b1;
      bus_rdata  = 32'hBAD0_BAD0;
      stray_pend = 0;
    end
  endtask

  // Transaction-level arbitration: requesters keep their heads presented, so each
  // grant picks data unless an instruction waits and LIMIT data grants already ran.
  task automatic build_expected();
    int   ii = 0;
    int   di = 0;
    int   starve = 0;
    txn_t t;
    mm = mem;
    exp_q.delete();
    while (ii < iq.size() || di < dq.size()) begin
      if (di < dq.size() && (ii >= iq.size() || starve < LIMIT)) begin
        t = dq[di];
        starve = (ii < iq.size()) ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
        if (t.we) mm[t.addr] = t.wdata;
        else      t.rdata = mm.exists(t.addr) ? mm[t.addr] : init_word(t.addr);
        dq[di] = t;
        di++;
      end else begin
        t = iq[ii];
        starve = 0;
        t.rdata = mm.exists(t.addr) ? mm[t.addr] : init_word(t.addr);
        iq[ii] = t;
        ii++;
      end
      exp_q.push_back(t);
    end
  endtask

  task automatic drive_heads();
    if (ip < iq.size()) begin
      inst_ren  = 1'b1;
      inst_addr = iq[ip].addr;
    end else begin
      inst_ren = 1'b0;
    end
    if (dp < dq.size()) begin
      mem_wen  = dq[dp].we;
      mem_ren  = !dq[dp].we || dq[dp].both;
      mem_addr = dq[dp].addr;
      mem_dout = dq[dp].wdata;
    end else begin
      mem_ren = 1'b0;
      mem_wen = 1'b0;
    end
  endtask

  initial begin
    int    mem_cyc, inst_cyc, ntx, di, hi;
    bit    seen, got_ready;
    string order, exp3;
    txn_t  t;

    rst_n = 1'b0; inst_ren = 0; inst_addr = '0; mem_ren = 0; mem_wen = 0;
    mem_addr = '0; mem_dout = '0; bus_ack = 0; bus_rdata = '0;
    repeat (3) tick();
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_bus_we", 32'(bus_we), 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_inst_ready", 32'(inst_ready), 32'd0);
    check("rst_mem_ready", 32'(mem_ready), 32'd0);
    check("rst_inst_data", inst_data, 32'd0);
    check("rst_mem_din", mem_din, 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    rst_n = 1'b1;

    // Single fetch, latency 1: req on cycle 1, ready on cycle 3.
    mem[32'h10] = 32'h2402_0005;
    bus_lat = 1;
    inst_ren = 1'b1; inst_addr = 32'h10;
    #1 check("t1_if_stall_c0", 32'(if_stall), 32'd1);
    tick();
    check("t1_req_c1", 32'(bus_req), 32'd1);
    check("t1_addr_c1", bus_addr, 32'h10);
    check("t1_we_c1", 32'(bus_we), 32'd0);
    tick();
    check("t1_ready_c2", 32'(inst_ready), 32'd0);
    tick();
    check("t1_ready_c3", 32'(inst_ready), 32'd1);
    check("t1_data_c3", inst_data, 32'h2402_0005);
    check("t1_req_c3", 32'(bus_req), 32'd0);
    check("t1_if_stall_c3", 32'(if_stall), 32'd0);
    inst_ren = 1'b0;
    tick();
    check("t1_ready_c4", 32'(inst_ready), 32'd0);

    // Simultaneous fetch and store: store wins.
    bus_lat = 2;
    inst_ren = 1'b1; inst_addr = 32'h20;
    mem_wen = 1'b1; mem_addr = 32'h40; mem_dout = 32'hDEAD_BEEF;
    mem_cyc = -1; inst_cyc = -1; ntx = 0;
    for (int c = 1; c <= 40 && (mem_cyc < 0 || inst_cyc < 0); c++) begin
      tick();
      if (started) begin
        if (ntx == 0) begin
          check("t2_first_we", 32'(bus_we), 32'd1);
          check("t2_first_addr", bus_addr, 32'h40);
          check("t2_first_wdata", bus_wdata, 32'hDEAD_BEEF);
        end else begin
          check("t2_second_addr", bus_addr, 32'h20);
          check("t2_second_we", 32'(bus_we), 32'd0);
        end
        ntx++;
      end
      if (mem_ready)  begin mem_cyc = c;  mem_wen = 1'b0;  end
      if (inst_ready) begin inst_cyc = c; inst_ren = 1'b0; end
    end
    check("t2_order", 32'(mem_cyc > 0 && inst_cyc > mem_cyc), 32'd1);
    check("t2_inst_data", inst_data, init_word(32'h20));
    check("t2_mem_din_kept", mem_din, 32'd0);
    check("t2_stored", mem_rd(32'h40), 32'hDEAD_BEEF);

    // Starvation limit: six reads against a held fetch.
    bus_lat = 1;
    inst_ren = 1'b1; inst_addr = 32'h80;
    mem_ren = 1'b1; mem_addr = 32'h100; di = 0; order = "";
    for (int c = 0; c < 200 && (di < 6 || inst_ren); c++) begin
      tick();
      if (started) order = {order, (bus_addr == 32'h80) ? "I" : "D"};
      if (mem_ready) begin
        di++;
        if (di < 6) mem_addr = 32'h100 + 32'(4 * di);
        else        mem_ren = 1'b0;
      end
      if (inst_ready) inst_ren = 1'b0;
    end
    exp3 = "DDDDIDD";
    check("t3_count", 32'(order.len()), 32'(exp3.len()));
    for (int k = 0; k < exp3.len(); k++)
      check("t3_order", (k < order.len()) ? 32'(order[k]) : 32'd0, 32'(exp3[k]));
    check("t3_mem_din", mem_din, init_word(32'h114));

    // Unacked read aborts after TO wait cycles.
    bus_lat = NO_ACK;
    mem_ren = 1'b1; mem_addr = 32'h200; hi = 0; seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      tick();
      if (bus_req) hi++;
      if (mem_ready) begin seen = 1; mem_ren = 1'b0; end
    end
    check("t4_req_cycles", 32'(hi), 32'(TO));
    check("t4_ready", 32'(seen), 32'd1);
    check("t4_mem_din", mem_din, 32'd0);
    check("t4_timeout_err", 32'(timeout_err), 32'd1);

    // Reset in the middle of a data wait; the late ack must be ignored.
    mem_ren = 1'b1; mem_addr = 32'h300;
    tick();
    check("t5_req_before", 32'(bus_req), 32'd1);
    rst_n = 1'b0; mem_ren = 1'b0;
    #1 check("t5_req_async", 32'(bus_req), 32'd0);
    tick();
    check("t5_req_rst1", 32'(bus_req), 32'd0);
    tick();
    check("t5_req_rst2", 32'(bus_req), 32'd0);
    rst_n = 1'b1;
    stray_pend = 1;
    got_ready = 0;
    repeat (3) begin
      tick();
      if (mem_ready || inst_ready) got_ready = 1;
    end
    check("t5_no_ready", 32'(got_ready), 32'd0);
    check("t5_mem_din", mem_din, 32'd0);
    check("t5_inst_data", inst_data, 32'd0);
    check("t5_timeout_clr", 32'(timeout_err), 32'd0);

    // Randomized streams against the model.
    rand_lat = 1;
    for (int r = 0; r < 3; r++) begin
      iq.delete(); dq.delete();
      for (int k = 0; k < int'($urandom_range(3, 10)); k++) begin
        t = '0;
        t.addr = 32'h1000 + 32'(4 * $urandom_range(0, 15));
        iq.push_back(t);
      end
      for (int k = 0; k < int'($urandom_range(4, 14)); k++) begin
        t = '0;
        t.we    = (k == 0) ? 1'b0 : 1'($urandom_range(0, 1));
        t.both  = 1'($urandom_range(0, 1));
        t.addr  = 32'h2000 + 32'(4 * $urandom_range(0, 7));
        t.wdata = $urandom;
        dq.push_back(t);
      end
      build_expected();
      ip = 0; dp = 0; ek = 0;
      drive_heads();
      for (int c = 0; c < 3000 && (ip < iq.size() || dp < dq.size()); c++) begin
        tick();
        check("if_stall", 32'(if_stall), 32'(inst_ren & ~inst_ready));
        check("mem_stall", 32'(mem_stall), 32'((mem_ren | mem_wen) & ~mem_ready));
        if (started) begin
          if (ek < exp_q.size()) begin
            check("txn_addr", bus_addr, exp_q[ek].addr);
            check("txn_we", 32'(bus_we), 32'(exp_q[ek].we));
            if (exp_q[ek].we) check("txn_wdata", bus_wdata, exp_q[ek].wdata);
          end
          ek++;
        end else if (bus_req) begin
          check("bus_hold_addr", bus_addr, req_addr);
          check("bus_hold_we", 32'(bus_we), 32'(req_we));
          check("bus_hold_wdata", bus_wdata, req_wdata);
        end
        if (inst_ready) begin
          if (ip < iq.size()) begin
            exp_inst_data = iq[ip].rdata;
            check("inst_data", inst_data, exp_inst_data);
          end
          ip++;
        end
        if (mem_ready) begin
          if (dp < dq.size()) begin
            if (!dq[dp].we) exp_mem_din = dq[dp].rdata;
            check("mem_din", mem_din, exp_mem_din);
          end
          dp++;
        end
        drive_heads();
      end
      check("round_inst_done", 32'(ip), 32'(iq.size()));
      check("round_data_done", 32'(dp), 32'(dq.size()));
      check("round_txn_total", 32'(ek), 32'(exp_q.size()));
    end
    check("rand_timeout_err", 32'(timeout_err), 32'd0);

    // Stray ack while idle.
    rand_lat = 0;
    tick();
    stray_pend = 1;
    got_ready = 0;
    repeat (3) begin
      tick();
      if (mem_ready || inst_ready) got_ready = 1;
    end
    check("t6_no_ready", 32'(got_ready), 32'd0);
    check("t6_inst_data", inst_data, exp_inst_data);
    check("t6_mem_din", mem_din, exp_mem_din);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at t=%0t, expected finish earlier", $time);
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
